// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Iteration counter must hold the value DIV_WIDTH itself.
  localparam int unsigned CNT_W = $clog2(DIV_WIDTH + 1);

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational WIDTH+1-bit trial subtract: i_a - {0, i_b}.
// Formed as i_a + ~{0, i_b} + 1 so it maps onto the shared adder.
module div_trial_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  logic [WIDTH:0] w_sum;

  assign w_sum    = i_a + {1'b1, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign o_diff   = w_sum[WIDTH-1:0];
  assign o_borrow = w_sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// One quotient bit per clock behind a start/busy/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t r_state, w_next;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_signed;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH-1:0] r_quo;
  // The top bit of the WIDTH+1 partial remainder is always zero between
  // iterations (prem < |divisor|), so only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r_prem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_prem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_dvs_zero;

  assign w_abs_dvd  = (r_signed && r_dvd[WIDTH-1]) ? -r_dvd : r_dvd;
  assign w_abs_dvs  = (r_signed && r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;
  assign w_prem_sh  = {r_prem, r_quo[WIDTH-1]};
  assign w_dvs_zero = (divisor == '0);

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .i_a      (w_prem_sh),
    .i_b      (r_dvs_mag),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_dvs_zero ? S_DONE : S_PREP;
      S_PREP: w_next = S_ITER;
      S_ITER: if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_signed    <= 1'b0;
      r_dvs_mag   <= '0;
      r_quo       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            r_signed <= is_signed;
            if (w_dvs_zero) begin
              r_quotient  <= WIDTH'(DBZ_QUOTIENT);
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end
          end
        end
        S_PREP: begin
          r_quo     <= w_abs_dvd;
          r_dvs_mag <= w_abs_dvs;
          r_neg_q   <= r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1];
          r_neg_r   <= r_dvd[WIDTH-1];
          r_prem    <= '0;
          r_cnt     <= CNT_W'(WIDTH);
        end
        S_ITER: begin
          r_prem <= w_borrow ? w_prem_sh[WIDTH-1:0] : w_diff;
          r_quo  <= {r_quo[WIDTH-2:0], ~w_borrow};
          r_cnt  <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_quotient  <= (r_signed && r_neg_q) ? -r_quo : r_quo;
          r_remainder <= (r_signed && r_neg_r) ? -r_prem : r_prem;
          r_dbz       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider for MIPS32 DIV/DIVU; it produces the quotient and remainder that are written to the LO and HI registers. It sits directly downstream of the 32-bit two's-complement subtract datapath. Each iteration consumes one trial subtraction of the divisor from the shifted partial remainder and commits or discards it based on the borrow. One quotient bit is resolved per clock, behind a start/busy/done handshake.

## Interface
- WIDTH, 32, operand and result width.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; accepted only when busy=0.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  in  WIDTH  sampled with start.
- divisor  in  WIDTH  sampled with start.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  single-cycle pulse when results are valid.
- quotient  out  WIDTH  LO value; held until the next accepted start.
- remainder  out  WIDTH  HI value; held until the next accepted start.
- div_by_zero  out  1  flag for the last operation; valid with done, held.

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 latches the operands and is_signed, and goes to PREP.
  - A zero divisor goes to DONE instead.
- PREP:
  - Forms |dividend| and |divisor| (absolute value only when is_signed).
  - Records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clears the partial remainder (WIDTH+1 bits) and loads the iteration counter with WIDTH.
- ITER, once per cycle:
  - Shift {prem, quo} left by 1.
  - trial = prem_shifted − {0, |divisor|}, computed WIDTH+1 bits wide.
  - If trial[WIDTH] = 0: prem = trial, quotient LSB = 1. Otherwise keep prem_shifted, quotient LSB = 0.
  - Decrement the counter; when it reaches 0, go to FIX.
- FIX:
  - Negate the quotient if is_signed and sign_q.
  - Negate the remainder if is_signed and sign_r.
  - Load the output registers and go to DONE.
- DONE: pulse done, then go to IDLE.
- Divide by zero:
  - quotient = all ones, remainder = dividend unchanged, div_by_zero = 1.
  - No iterations are performed.
- Signed overflow (0x80000000 / −1) is not special-cased: quotient = 0x80000000, remainder = 0.
- start while busy=1 is ignored, with no queueing.
- Unsigned operation treats operands as plain WIDTH-bit magnitudes; there is no sign step.
- The remainder sign follows the dividend, so |remainder| < |divisor| always holds.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, FSM=IDLE.
- The cycle in which start is sampled in IDLE is cycle t.
  - Normal operation: PREP at t+1, ITER at t+2 … t+WIDTH+1, FIX at t+WIDTH+2, done=1 at t+WIDTH+3 (t+35 for WIDTH=32).
  - Divide by zero: done=1 at t+1.
- busy = 1 in every non-IDLE state. It drops to 0 in the cycle after done, and a new start is accepted from that cycle on.
- Outputs update only in the FIX (or zero-divisor) transition. They are stable when done is high and stay stable after it.
- rst=1 at any cycle aborts the operation:
  - Next cycle: IDLE, all outputs at their reset values.
  - No done pulse is produced for the aborted operation.
- rst and start in the same cycle: rst wins and start is dropped.

## Structure
- Shared package (div_pkg):
  - FSM state enum.
  - Counter width constant $clog2(WIDTH+1).
  - The all-ones quotient constant for divide by zero.
- One sub-module, div_trial_sub:
  - Combinational WIDTH+1-bit trial subtract.
  - Outputs the difference and a borrow flag (trial[WIDTH]).
  - Built as ~divisor plus carry-in 1 through the team's adder.
- Everything else (FSM, shift registers, sign fix-up) stays in seq_divider.

## Test plan
- Unsigned 100 / 7, start at t → done at t+35; quotient=14, remainder=2; div_by_zero=0; busy low at t+36.
- Signed −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- Divisor 0, dividend 0x1234 → done at t+1; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Unsigned 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
- Unsigned 5 / 9 → quotient=0, remainder=5.
- Start at t, second start at t+5 with different operands → ignored; first result only.
- Start at t, rst at t+10 → busy=0 and outputs 0 at t+11; no done through t+40.
